fp8_stream_accumulator: RTL and testbench

//  Sequential front/back end for the 8-bit float adder/subtractor (1 sign, 3 exp, 4 mantissa).

---
 rtl/fp8_stream_accumulator_if.sv | 30 +++
 rtl/fp8_stream_accumulator.sv | 100 ++++++++++
 tb/tb_fp8_stream_accumulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fp8_stream_accumulator_if.sv
// fp8_stream_accumulator_if: operand stream, adder hookup and result stream of the FP8 accumulator.
interface fp8_stream_accumulator_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_sub;
    logic             in_last;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_op;
    logic [7:0]       add_result;
    logic [4:0]       add_flags;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic [4:0]       out_flags;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_sub, in_last, add_result, add_flags, out_ready,
        output in_ready, add_a, add_b, add_op, out_valid, out_sum, out_flags, out_count
    );

    modport master (
        output in_valid, in_data, in_sub, in_last, add_result, add_flags, out_ready,
        input  in_ready, add_a, add_b, add_op, out_valid, out_sum, out_flags, out_count
    );
endinterface

// File: rtl/fp8_stream_accumulator.sv
// fp8_stream_accumulator: packet accumulator around an external combinational FP8 adder.
// Define FP8_ACC_SATURATE_EN to clamp overflowed running sums to max finite, sign kept.
module fp8_stream_accumulator #(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 255
) (
    input logic                         clk,
    input logic                         rst,
    fp8_stream_accumulator_if.slave     bus
);
    localparam logic [1:0] ACCEPT = 2'd0;
    localparam logic [1:0] ADD    = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [7:0]       add_a_q, add_a_d;
    logic [7:0]       add_b_q, add_b_d;
    logic             add_op_q, add_op_d;
    logic [7:0]       acc_q, acc_d;
    logic [4:0]       flags_q, flags_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [7:0]       add_sum;

`ifdef FP8_ACC_SATURATE_EN
    assign add_sum = bus.add_flags[4] ? (bus.add_result[7] ? 8'hEF : 8'h6F) : bus.add_result;
`else
    assign add_sum = bus.add_result;
`endif

    always_comb begin
        state_d  = state_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_op_d = add_op_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        count_d  = count_q;
        first_d  = first_q;
        last_d   = last_q;
        if (state_q == ACCEPT && bus.in_valid && in_ready_q) begin
            add_a_d  = first_q ? 8'h00 : acc_q;
            add_b_d  = bus.in_data;
            add_op_d = bus.in_sub;
            count_d  = count_q + CNT_W'(1);
            last_d   = bus.in_last | (count_q == LAST_CNT);
            state_d  = ADD;
        end else if (state_q == ADD) begin
            acc_d   = add_sum;
            flags_d = flags_q | bus.add_flags;
            first_d = 1'b0;
            state_d = last_q ? DONE : ACCEPT;
        end else if (state_q == DONE && bus.out_ready) begin
            acc_d   = 8'h00;
            flags_d = 5'h00;
            count_d = '0;
            first_d = 1'b1;
            state_d = ACCEPT;
        end
        in_ready_d = state_d == ACCEPT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b0;
            add_a_q    <= 8'h00;
            add_b_q    <= 8'h00;
            add_op_q   <= 1'b0;
            acc_q      <= 8'h00;
            flags_q    <= 5'h00;
            count_q    <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_op_q   <= add_op_d;
            acc_q      <= acc_d;
            flags_q    <= flags_d;
            count_q    <= count_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_op    = add_op_q;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_sum   = acc_q;
    assign bus.out_flags = flags_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_fp8_stream_accumulator.sv
// tb_fp8_stream_accumulator: directed packets through the accumulator with a behavioural FP8 adder.
module tb_fp8_stream_accumulator;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    fp8_stream_accumulator_if #(.CNT_W(CNT_W)) bus ();

    fp8_stream_accumulator #(.CNT_W(CNT_W), .MAX_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Finite operands only; values held as integers in units of 2^-6, round to nearest even.
    function automatic int fp8_val(input logic [7:0] x);
        int mag;
        mag = (x[6:4] == 3'd0) ? int'(x[3:0]) : (16 + int'(x[3:0])) << (int'(x[6:4]) - 1);
        return x[7] ? -mag : mag;
    endfunction

    function automatic logic [12:0] fp8_add(input logic [7:0] a, b, input logic op);
        int sum, m, s, q, rem, half;
        logic sgn, inx;
        sum = fp8_val(a) + (op ? -fp8_val(b) : fp8_val(b));
        sgn = sum < 0;
        m   = sgn ? -sum : sum;
        if (m < 32) return {sgn, (m >= 16) ? 3'd1 : 3'd0, 4'(m), 5'h00};
        s = 0;
        while ((m >> s) > 31) s++;
        q    = m >> s;
        rem  = m - (q << s);
        half = 1 << (s - 1);
        inx  = rem != 0;
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 32) begin
            q = 16;
            s++;
        end
        if (s + 1 >= 7) return {sgn, 7'h70, 5'b10001};
        return {sgn, 3'(s + 1), 4'(q), 4'b0000, inx};
    endfunction

    always_comb {bus.add_result, bus.add_flags} = fp8_add(bus.add_a, bus.add_b, bus.add_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic sub, input logic last);
        int n = 0;
        bus.in_data  = d;
        bus.in_sub   = sub;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("rel_out_valid", bus.out_valid, 0);
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_count", bus.out_count, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_sum"}, bus.out_sum, 0);
        chk({tag, "_out_flags"}, bus.out_flags, 0);
        chk({tag, "_out_count"}, bus.out_count, 0);
        chk({tag, "_add_a"}, bus.add_a, 0);
        chk({tag, "_add_b"}, bus.add_b, 0);
        chk({tag, "_add_op"}, bus.add_op, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sub    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready_rise", bus.in_ready, 1);

        // 1.0 + 1.0
        send(8'h30, 1'b0, 1'b0);
        chk("t1_add_a0", bus.add_a, 8'h00);
        chk("t1_add_b0", bus.add_b, 8'h30);
        send(8'h30, 1'b0, 1'b1);
        chk("t1_add_a1", bus.add_a, 8'h30);
        chk("t1_add_op1", bus.add_op, 0);
        wait_done();
        chk("t1_sum", bus.out_sum, 8'h40);
        chk("t1_flags", bus.out_flags, 5'h00);
        chk("t1_count", bus.out_count, 2);

        // result held while consumer stalls
        repeat (5) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", bus.out_valid, 1);
            chk("t4_hold_sum", bus.out_sum, 8'h40);
            chk("t4_hold_in_ready", bus.in_ready, 0);
        end
        release_out();

        // 2.0 - 1.0, sum restarts from zero
        send(8'h40, 1'b0, 1'b0);
        chk("t2_add_a0", bus.add_a, 8'h00);
        send(8'h30, 1'b1, 1'b1);
        chk("t2_add_op1", bus.add_op, 1);
        chk("t2_add_a1", bus.add_a, 8'h40);
        wait_done();
        chk("t2_sum", bus.out_sum, 8'h30);
        chk("t2_flags", bus.out_flags, 5'h00);
        chk("t2_count", bus.out_count, 2);
        release_out();

        // 15.5 + 15.5 overflows
        send(8'h6F, 1'b0, 1'b0);
        send(8'h6F, 1'b0, 1'b1);
        wait_done();
        chk("t3_ovf", bus.out_flags[4], 1);
`ifdef FP8_ACC_SATURATE_EN
        chk("t3_sum_sat", bus.out_sum, 8'h6F);
`else
        chk("t3_sum_inf", bus.out_sum, 8'h70);
`endif
        chk("t3_count", bus.out_count, 2);
        release_out();

        // MAX_LEN=4 closes the packet without in_last
        repeat (4) send(8'h30, 1'b0, 1'b0);
        wait_done();
        chk("t5_sum", bus.out_sum, 8'h50);
        chk("t5_count", bus.out_count, 4);
        chk("t5_flags", bus.out_flags, 5'h00);
        release_out();
        send(8'h30, 1'b0, 1'b0);
        chk("t5_new_add_a", bus.add_a, 8'h00);
        send(8'h30, 1'b0, 1'b1);
        wait_done();
        chk("t5_next_sum", bus.out_sum, 8'h40);
        chk("t5_next_count", bus.out_count, 2);
        release_out();

        // reset during ADD of operand 3
        send(8'h30, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        chk("t6_pre_count", bus.out_count, 3);
        rst = 1'b1;
        #1;
        chk_reset_state("t6");
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_in_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("t6_in_ready_rise", bus.in_ready, 1);
        send(8'h30, 1'b0, 1'b1);
        wait_done();
        chk("t6_sum", bus.out_sum, 8'h30);
        chk("t6_count", bus.out_count, 1);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
